// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter
// Read-side consumer of an async FIFO in the rd_clk domain. Prefetches words
// into a small circular skid buffer and presents them as a first-word-fall-through
// valid/ready stream. The FIFO read request depends only on registered occupancy
// and the empty flag, so out_ready never reaches back to the FIFO combinationally.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                           rd_clk,
  input  logic                           rd_rst,
  output logic                           fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]          fifo_rd_data,
  input  logic                           fifo_rd_empty,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count,
  output logic                           overflow_err
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_X  = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  in_flight_q;
  logic                  ovf_q, ovf_d;
  logic                  pop;
  logic                  land_ok;

  // Circular pointer advance; depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A read is issued only if the word it returns is guaranteed a free slot,
  // counting the word already in flight.
  assign fifo_rd_en = !rd_rst && !fifo_rd_empty &&
                      (({1'b0, count_q} + (CNT_W + 1)'(in_flight_q)) < DEPTH_X);

  // Head entry is the stream beat; forced to zero while the buffer is empty.
  assign out_valid    = (count_q != '0);
  assign out_data     = out_valid ? buf_q[head_q] : '0;
  assign buf_count    = count_q;
  assign overflow_err = ovf_q;

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    pop     = out_valid && out_ready;
    land_ok = in_flight_q && ((count_q != FULL) || pop);
    head_d  = pop ? ptr_inc(head_q) : head_q;
    tail_d  = land_ok ? ptr_inc(tail_q) : tail_q;
    count_d = count_q;
    if (land_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!land_ok && pop) begin
      count_d = count_q - 1'b1;
    end
    ovf_d = ovf_q || (in_flight_q && !land_ok);
  end

  // Control state; reset drops any read in flight.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      in_flight_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      in_flight_q <= fifo_rd_en;
      ovf_q       <= ovf_d;
    end
  end

  // Buffer storage: the returning FIFO word lands at tail one cycle after the request.
  always_ff @(posedge rd_clk) begin
    if (!rd_rst && land_ok) begin
      buf_q[tail_q] <= fifo_rd_data;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: behavioural FIFO source, word scoreboard,
// directed latency/backpressure/reset scenarios and randomized mixed traffic.
module tb_fifo_rd_stream_adapter;

  localparam int DW    = 32;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] buf_count;
  logic          overflow_err;

  int checks = 0;
  int errors = 0;

  // Behavioural source FIFO: array plus read/write indices, 1-cycle read latency.
  logic [DW-1:0] mem [256];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  bit            hold_empty = 1'b0;
  // Words requested from the FIFO and not yet consumed downstream, in order.
  logic [DW-1:0] exp_q [$];

  assign fifo_rd_empty = hold_empty || (rd_ptr == wr_ptr);

  fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH)) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_empty(fifo_rd_empty),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .buf_count    (buf_count),
    .overflow_err (overflow_err)
  );

  always #5 rd_clk = ~rd_clk;

  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_ptr % 256];
      rd_ptr       <= rd_ptr + 1;
    end
    if (rd_rst) exp_q.delete();
    else if (fifo_rd_en) exp_q.push_back(mem[rd_ptr % 256]);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [DW-1:0] w);
    mem[wr_ptr % 256] = w;
    wr_ptr++;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (exp_q.size() != 0 || rd_ptr != wr_ptr) begin
      @(negedge rd_clk);
      out_ready  = 1'b1;
      hold_empty = 1'b0;
      #1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_beat got %0h want none", tag, out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            errors++;
            $display("FAIL %s_order got %0h want %0h", tag, out_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      n++;
      if (n > budget) begin
        checks++; errors++;
        $display("FAIL %s_timeout got %0d pending want 0", tag, exp_q.size());
        break;
      end
    end
    @(negedge rd_clk); #1;
    checks++;
    if (buf_count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_empty_after got count=%0d valid=%b want 0/0", tag, buf_count, out_valid);
    end
  endtask

  task automatic test_reset();
    push_word(32'hDEAD_0000);
    push_word(32'hDEAD_0001);
    for (int c = 0; c < 2; c++) begin
      @(negedge rd_clk); #1;
      checks++;
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++;
      if (buf_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", buf_count); end
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", out_data); end
      checks++;
      if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow_err); end
    end
    @(negedge rd_clk);
    rd_rst = 1'b0;
    drain("reset_release", 30);
  endtask

  task automatic test_single();
    @(negedge rd_clk);
    out_ready  = 1'b1;
    hold_empty = 1'b0;
    push_word(32'hA5A5_0001);
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en got %b want 1", fifo_rd_en); end
    @(negedge rd_clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %b want 0", out_valid); end
    @(negedge rd_clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL single_beat got v=%b d=%0h want v=1 d=a5a50001", out_valid, out_data);
    end
    if (out_valid && exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge rd_clk); #1;
    checks++;
    if (buf_count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_count_back got count=%0d valid=%b want 0/0", buf_count, out_valid);
    end
  endtask

  task automatic test_stream();
    bit exp_v;
    @(negedge rd_clk);
    hold_empty = 1'b1;
    out_ready  = 1'b1;
    for (int i = 0; i < 16; i++) push_word(32'(i));
    @(negedge rd_clk);
    hold_empty = 1'b0;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL stream_first_rd got %b want 1", fifo_rd_en); end
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin @(negedge rd_clk); #1; end
      exp_v = (k >= 2 && k < 18);
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL stream_valid_k%0d got %b want %b", k, out_valid, exp_v);
      end
      if (out_valid) begin
        if (exp_v) begin
          checks++;
          if (out_data !== 32'(k - 2)) begin
            errors++;
            $display("FAIL stream_data_k%0d got %0h want %0h", k, out_data, k - 2);
          end
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    @(negedge rd_clk);
    hold_empty = 1'b1;
    out_ready  = 1'b0;
    for (int i = 0; i < 10; i++) push_word(32'h1000_0000 + 32'(i));
    @(negedge rd_clk);
    hold_empty = 1'b0;
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(negedge rd_clk); #1; end
      if (fifo_rd_en) pulses++;
      if (out_valid) begin
        checks++;
        if (out_data !== 32'h1000_0000) begin
          errors++;
          $display("FAIL bp_hold_k%0d got %0h want 10000000", k, out_data);
        end
      end
    end
    checks++;
    if (pulses != 3) begin errors++; $display("FAIL bp_rd_pulses got %0d want 3", pulses); end
    checks++;
    if (buf_count !== CW'(3)) begin errors++; $display("FAIL bp_count got %0d want 3", buf_count); end
    for (int k = 0; k < 11; k++) begin
      @(negedge rd_clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if (k < 10) begin
        if (out_valid !== 1'b1 || out_data !== 32'h1000_0000 + 32'(k)) begin
          errors++;
          $display("FAIL bp_release_k%0d got v=%b d=%0h want v=1 d=%0h", k, out_valid, out_data,
                   32'h1000_0000 + 32'(k));
        end
        if (out_valid && exp_q.size() != 0) void'(exp_q.pop_front());
      end else if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_tail_valid got %b want 0", out_valid);
      end
    end
  endtask

  task automatic test_mixed(input int phase);
    int   total = 40;
    int   popped = 0;
    int   k = 0;
    logic prev = 1'b0;
    @(negedge rd_clk);
    hold_empty = 1'b1;
    out_ready  = 1'b0;
    for (int i = 0; i < total; i++) push_word($urandom());
    while (popped < total && k < 600) begin
      @(negedge rd_clk);
      if (phase == 0) begin
        out_ready  = (k % 2 == 0);
        hold_empty = ((k / 3) % 2 == 1);
      end else begin
        out_ready  = 1'($urandom_range(0, 1));
        hold_empty = ($urandom_range(0, 3) == 0);
      end
      #1;
      checks++;
      if (int'(buf_count) != exp_q.size() - int'(prev)) begin
        errors++;
        $display("FAIL mixed%0d_count_k%0d got %0d want %0d", phase, k, buf_count,
                 exp_q.size() - int'(prev));
      end
      checks++;
      if (buf_count > CW'(DEPTH) || overflow_err !== 1'b0) begin
        errors++;
        $display("FAIL mixed%0d_bounds_k%0d got count=%0d ovf=%b want <=3/0", phase, k, buf_count,
                 overflow_err);
      end
      checks++;
      if (fifo_rd_en && fifo_rd_empty) begin
        errors++;
        $display("FAIL mixed%0d_rd_when_empty_k%0d got 1 want 0", phase, k);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0 || out_data !== exp_q[0]) begin
          errors++;
          $display("FAIL mixed%0d_order_k%0d got %0h want %0h", phase, k, out_data,
                   (exp_q.size() != 0) ? exp_q[0] : 'x);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        popped++;
      end
      prev = fifo_rd_en;
      k++;
    end
    checks++;
    if (popped != total) begin
      errors++;
      $display("FAIL mixed%0d_timeout got %0d beats want %0d", phase, popped, total);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    @(negedge rd_clk);
    hold_empty = 1'b1;
    out_ready  = 1'b0;
    for (int i = 0; i < 6; i++) push_word(32'h2000_0000 + 32'(i));
    @(negedge rd_clk);
    hold_empty = 1'b0;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin errors++; $display("FAIL rmid_rd_en got %b want 1", fifo_rd_en); end
    @(negedge rd_clk);
    rd_rst = 1'b1;
    @(negedge rd_clk); #1;
    checks++;
    if (out_valid !== 1'b0 || buf_count !== '0 || out_data !== '0 || fifo_rd_en !== 1'b0 ||
        overflow_err !== 1'b0) begin
      errors++;
      $display("FAIL rmid_outputs got v=%b c=%0d d=%0h rd=%b ovf=%b want all 0", out_valid,
               buf_count, out_data, fifo_rd_en, overflow_err);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge rd_clk);
      rd_rst    = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        checks++;
        if (out_data !== 32'h2000_0001) begin
          errors++;
          $display("FAIL rmid_first_after got %0h want 20000001", out_data);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL rmid_resume got no beat want 20000001");
    end
    drain("rmid_drain", 40);
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_mixed(0);
    test_mixed(1);
    test_reset_mid();
    checks++;
    if (overflow_err !== 1'b0) begin errors++; $display("FAIL final_ovf got %b want 0", overflow_err); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
